// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD packer.
// FSM encoding, saturation limit, default blank nibble, counter width.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_FINISH
  } state_t;

  localparam int MAX_VAL = 9999;
  localparam int W_DEF = 14;
  localparam int CNT_W = $clog2(W_DEF + 1);
  localparam logic [3:0] BLANK_DEF = 4'hF;

endpackage

// File: rtl/bcd_dabble_core.sv
// One double-dabble channel: saturating latch, BCD register, add-3/shift.
// Ports: clk/rst, load (latch val), step (one iteration), bcd, ovf.
module bcd_dabble_core
  import bcd_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic [W-1:0]          val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BW = 4 * DIGITS;
  localparam logic [W-1:0] LIM = W'(MAX_VAL);

  logic [W-1:0]  bin_q;
  logic [BW-1:0] bcd_q;
  logic [BW-1:0] adj;
  logic          ovf_q;

  // Correct each nibble before the shift so it carries as decimal.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else if (load) begin
      bin_q <= (val > LIM) ? LIM : val;
      bcd_q <= '0;
      ovf_q <= (val > LIM);
    end else if (step) begin
      bcd_q <= {adj[BW-2:0], bin_q[W-1]};
      bin_q <= {bin_q[W-2:0], 1'b0};
    end
  end

  assign bcd = bcd_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/bcd_packer.sv
// Two-channel sequential binary-to-BCD converter with saturation and
// leading-zero blanking; drives a registered packed-BCD word to the tubes.
// Ports: sys_clk, sys_rst, start, val_hi, val_lo -> busy, valid,
//        ovf_hi, ovf_lo, data (hi group in upper half, lo group lower).
module bcd_packer
  import bcd_pkg::*;
#(
  parameter int         W = W_DEF,
  parameter int         DIGITS = 4,
  parameter bit         LZ_BLANK = 1'b1,
  parameter logic [3:0] BLANK_CODE = BLANK_DEF
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic [W-1:0]          val_hi,
  input  logic [W-1:0]          val_lo,
  output logic                  busy,
  output logic                  valid,
  output logic                  ovf_hi,
  output logic                  ovf_lo,
  output logic [8*DIGITS-1:0]   data
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          load;
  logic          step;
  logic          fin;
  logic [BW-1:0] bcd_hi;
  logic [BW-1:0] bcd_lo;
  logic          sat_hi;
  logic          sat_lo;

  // Units digit is never blanked so zero still shows as "0".
  function automatic logic [BW-1:0] blank_grp(input logic [BW-1:0] d);
    logic [BW-1:0] o;
    logic          lead;
    o = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (lead && d[i*4 +: 4] == 4'd0)
        o[i*4 +: 4] = BLANK_CODE;
      else
        lead = 1'b0;
    end
    return LZ_BLANK ? o : d;
  endfunction

  bcd_dabble_core #(.W(W), .DIGITS(DIGITS)) u_hi (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .load (load),
    .step (step),
    .val  (val_hi),
    .bcd  (bcd_hi),
    .ovf  (sat_hi)
  );

  bcd_dabble_core #(.W(W), .DIGITS(DIGITS)) u_lo (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .load (load),
    .step (step),
    .val  (val_lo),
    .bcd  (bcd_lo),
    .ovf  (sat_lo)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load = 1'b0;
    step = 1'b0;
    fin = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          load = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        step = 1'b1;
        if (cnt_q == LAST) state_d = S_FINISH;
      end
      S_FINISH: begin
        fin = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst)   cnt_q <= '0;
    else if (load) cnt_q <= '0;
    else if (step) cnt_q <= cnt_q + CW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      data <= '1;
      valid <= 1'b0;
      ovf_hi <= 1'b0;
      ovf_lo <= 1'b0;
    end else begin
      valid <= fin;
      if (fin) begin
        data <= {blank_grp(bcd_hi), blank_grp(bcd_lo)};
        ovf_hi <= sat_hi;
        ovf_lo <= sat_lo;
      end
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_bcd_packer.sv
// Self-checking bench for bcd_packer: directed cases plus random values,
// checked against an arithmetic decimal model (blanked and unblanked DUTs).
module tb_bcd_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [13:0] val_hi = '0;
  logic [13:0] val_lo = '0;
  logic        busy, valid, ovf_hi, ovf_lo;
  logic [31:0] data;
  logic        busy2, valid2, ovf_hi2, ovf_lo2;
  logic [31:0] data2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_packer dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .start   (start),
    .val_hi  (val_hi),
    .val_lo  (val_lo),
    .busy    (busy),
    .valid   (valid),
    .ovf_hi  (ovf_hi),
    .ovf_lo  (ovf_lo),
    .data    (data)
  );

  bcd_packer #(.LZ_BLANK(1'b0)) dut_nb (
    .sys_clk (clk),
    .sys_rst (rst),
    .start   (start),
    .val_hi  (val_hi),
    .val_lo  (val_lo),
    .busy    (busy2),
    .valid   (valid2),
    .ovf_hi  (ovf_hi2),
    .ovf_lo  (ovf_lo2),
    .data    (data2)
  );

  function automatic logic [15:0] ref_grp(input int v, input bit lz);
    int s;
    int p;
    logic [15:0] r;
    s = (v > 9999) ? 9999 : v;
    p = 1;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (lz && i > 0 && s < p) r[i*4 +: 4] = 4'hF;
      else r[i*4 +: 4] = 4'((s / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch one conversion and check the whole 16-cycle window.
  task automatic convert(input int hi, input int lo, input bit scramble);
    @(negedge clk);
    val_hi = 14'(hi);
    val_lo = 14'(lo);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        val_hi = 14'($urandom_range(0, 16383));
        val_lo = 14'($urandom_range(0, 16383));
      end
      chk("busy_window", {30'd0, valid, busy}, 32'd1);
    end
    @(negedge clk);
    chk("done_flags", {30'd0, valid, busy}, 32'd2);
    chk("data", data, {ref_grp(hi, 1'b1), ref_grp(lo, 1'b1)});
    chk("data_noblank", data2, {ref_grp(hi, 1'b0), ref_grp(lo, 1'b0)});
    chk("ovf", {30'd0, ovf_hi, ovf_lo}, {30'd0, hi > 9999, lo > 9999});
  endtask

  initial begin
    int nv;
    repeat (3) @(negedge clk);
    chk("reset_flags", {28'd0, busy, valid, ovf_hi, ovf_lo}, 32'd0);
    chk("reset_data", data, 32'hFFFF_FFFF);
    rst = 1'b0;

    convert(1234, 56, 1'b0);
    chk("data_1234_56", data, 32'h1234_FF56);
    convert(0, 0, 1'b0);
    chk("data_zero", data, 32'hFFF0_FFF0);
    chk("data_zero_nb", data2, 32'h0000_0000);
    convert(16383, 10000, 1'b0);
    chk("data_sat", data, 32'h9999_9999);
    convert(9999, 7, 1'b0);
    chk("data_9999_7", data, 32'h9999_FFF7);

    // Inputs change and start re-pulses mid-conversion.
    @(negedge clk);
    val_hi = 14'd4321;
    val_lo = 14'd8765;
    start = 1'b1;
    @(posedge clk);
    nv = 0;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      start = (k == 4);
      if (k == 4) begin
        val_hi = 14'd1;
        val_lo = 14'd1;
      end
      if (valid) nv++;
      if (k == 15) begin
        chk("ignored_start_valid", {31'd0, valid}, 32'd1);
        chk("ignored_start_data", data, 32'h4321_8765);
      end
    end
    chk("single_valid", nv, 1);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    val_hi = 14'd2222;
    val_lo = 14'd3333;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 7) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_flags", {30'd0, busy, valid}, 32'd0);
    chk("abort_data", data, 32'hFFFF_FFFF);
    nv = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid) nv++;
    end
    chk("abort_no_valid", nv, 0);
    convert(90, 9000, 1'b0);
    chk("data_90_9000", data, 32'hFF90_9000);

    // Start held high: one result every 16 cycles.
    @(negedge clk);
    val_hi = 14'd1000;
    val_lo = 14'd1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (k == 47) start = 1'b0;
      chk("held_valid", {31'd0, valid}, {31'd0, (k % 16) == 15});
      if (valid) chk("held_data", data, 32'h1000_FFF1);
    end

    for (int n = 0; n < 24; n++)
      convert(int'($urandom_range(0, 16383)),
              (n % 3 == 0) ? int'($urandom_range(0, 120))
                           : int'($urandom_range(0, 16383)), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
